// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and its hazard controller.
// The pipeline side is the master; hazard_ctrl is the slave.
interface hazard_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    logic [4:0]             rs1_d;
    logic [4:0]             rs2_d;
    logic [4:0]             rs1_e;
    logic [4:0]             rs2_e;
    logic [4:0]             rd_e;
    logic [1:0]             res_src_e;
    logic                   pc_src_e;
    logic                   mdu_req_e;
    logic                   mdu_done;
    logic [4:0]             rd_m;
    logic                   reg_write_m;
    logic [4:0]             rd_w;
    logic                   reg_write_w;

    logic [1:0]             forward_a_e;
    logic [1:0]             forward_b_e;
    logic                   stall_f;
    logic                   stall_d;
    logic                   stall_e;
    logic                   flush_d;
    logic                   flush_e;
    logic                   flush_m;
    logic                   mdu_start;
    logic                   mdu_busy;
    logic                   mdu_timeout;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
               mdu_req_e, mdu_done, rd_m, reg_write_m, rd_w, reg_write_w,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
               flush_d, flush_e, flush_m, mdu_start, mdu_busy,
               mdu_timeout, stall_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
               mdu_req_e, mdu_done, rd_m, reg_write_m, rd_w, reg_write_w,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
               flush_d, flush_e, flush_m, mdu_start, mdu_busy,
               mdu_timeout, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: operand forwarding, load-use
// stalls, branch flushes, MDU start/done sequencing and a stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MDU_TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic lw_stall;
    logic mdu_hold;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && rd_m != 5'd0 && rd_m == src) return 2'b10;
        if (wr_w && rd_w != 5'd0 && rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    assign bus.forward_a_e = fwd_sel(bus.rs1_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);
    assign bus.forward_b_e = fwd_sel(bus.rs2_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);

    assign lw_stall = (bus.res_src_e == 2'b01) && (bus.rd_e != 5'd0) &&
                      ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    // An MDU op in flight freezes the front end and bubbles memory; it can never branch.
    assign mdu_hold = !rst && (((state_q == IDLE) && bus.mdu_req_e) || (state_q == BUSY));

    always_comb begin
        bus.stall_f   = 1'b0;
        bus.stall_d   = 1'b0;
        bus.stall_e   = 1'b0;
        bus.flush_d   = 1'b0;
        bus.flush_e   = 1'b0;
        bus.flush_m   = 1'b0;
        bus.mdu_start = 1'b0;
        bus.mdu_busy  = 1'b0;
        if (!rst) begin
            bus.mdu_start = (state_q == IDLE) && bus.mdu_req_e;
            bus.mdu_busy  = (state_q == BUSY);
            if (mdu_hold) begin
                bus.stall_f = 1'b1;
                bus.stall_d = 1'b1;
                bus.stall_e = 1'b1;
                bus.flush_m = 1'b1;
            end else begin
                bus.stall_f = lw_stall;
                bus.stall_d = lw_stall;
                bus.flush_d = bus.pc_src_e;
                bus.flush_e = lw_stall || bus.pc_src_e;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        stall_count_d = bus.stall_f ? sat_inc(stall_count_q) : stall_count_q;
        if (rst) begin
            state_d       = IDLE;
            cnt_d         = '0;
            timeout_d     = 1'b0;
            stall_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.mdu_req_e) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                end
                BUSY: begin
                    if (bus.mdu_done) begin
                        state_d = DONE;
                    end else if (cnt_q == CNT_W'(MDU_TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        timeout_q     <= timeout_d;
        stall_count_q <= stall_count_d;
    end

    assign bus.mdu_timeout = timeout_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_hazard_ctrl;
    localparam int  T    = 8;
    localparam int  W    = 4;
    localparam longint CMAX = (64'd1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    hazard_ctrl_if #(.STALL_CNT_W(W)) hif ();

    hazard_ctrl #(.MDU_TIMEOUT(T), .STALL_CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: phase 0 = no MDU op, 1 = waiting for result, 2 = result cycle.
    int     ph    = 0;
    int     age   = 0;
    bit     m_to  = 0;
    longint m_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_fwd(input logic [4:0] src);
        if (hif.reg_write_m && hif.rd_m != 0 && hif.rd_m == src) return 2;
        if (hif.reg_write_w && hif.rd_w != 0 && hif.rd_w == src) return 1;
        return 0;
    endfunction

    function automatic bit m_lw();
        return hif.res_src_e == 2'b01 && hif.rd_e != 0 &&
               (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
    endfunction

    function automatic bit m_hold();
        return !rst && ((ph == 0 && hif.mdu_req_e) || ph == 1);
    endfunction

    function automatic bit m_stall_f();
        if (rst) return 0;
        return m_hold() || m_lw();
    endfunction

    always @(negedge clk) begin
        chk("cyc_fwd_a", hif.forward_a_e, m_fwd(hif.rs1_e));
        chk("cyc_fwd_b", hif.forward_b_e, m_fwd(hif.rs2_e));
        chk("cyc_stall_f", hif.stall_f, m_stall_f());
        chk("cyc_stall_d", hif.stall_d, m_stall_f());
        chk("cyc_stall_e", hif.stall_e, m_hold());
        chk("cyc_flush_d", hif.flush_d, !rst && !m_hold() && hif.pc_src_e);
        chk("cyc_flush_e", hif.flush_e, !rst && !m_hold() && (hif.pc_src_e || m_lw()));
        chk("cyc_flush_m", hif.flush_m, m_hold());
        chk("cyc_start", hif.mdu_start, !rst && ph == 0 && hif.mdu_req_e);
        chk("cyc_busy", hif.mdu_busy, !rst && ph == 1);
        chk("cyc_timeout", hif.mdu_timeout, m_to);
        chk("cyc_count", hif.stall_count, m_cnt);
    end

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; age = 0; m_to = 0; m_cnt = 0;
        end else begin
            if (m_stall_f()) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            case (ph)
                0: if (hif.mdu_req_e) begin ph = 1; age = 0; end
                1: begin
                    if (hif.mdu_done) ph = 2;
                    else if (age == T - 1) begin ph = 0; m_to = 1; end
                    else age++;
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic clr();
        hif.rs1_d = 0; hif.rs2_d = 0; hif.rs1_e = 0; hif.rs2_e = 0; hif.rd_e = 0;
        hif.res_src_e = 0; hif.pc_src_e = 0; hif.mdu_req_e = 0; hif.mdu_done = 0;
        hif.rd_m = 0; hif.reg_write_m = 0; hif.rd_w = 0; hif.reg_write_w = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        hif.mdu_req_e = 1; hif.res_src_e = 1; hif.rd_e = 7; hif.rs2_d = 7; hif.pc_src_e = 1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall_f", hif.stall_f, 0);
            chk("rst_start", hif.mdu_start, 0);
            chk("rst_flush_e", hif.flush_e, 0);
            chk("rst_count", hif.stall_count, 0);
        end

        cyc(); rst = 1'b0; clr();
        hif.rs1_e = 5; hif.rd_m = 5; hif.reg_write_m = 1; hif.rd_w = 5; hif.reg_write_w = 1;
        @(negedge clk); chk("fwd_mw", hif.forward_a_e, 2);
        cyc(); hif.rd_m = 0;
        @(negedge clk); chk("fwd_w", hif.forward_a_e, 1);
        cyc(); hif.rd_w = 0;
        @(negedge clk); chk("fwd_none", hif.forward_a_e, 0);
        cyc(); clr(); hif.rs2_e = 9; hif.rd_w = 9; hif.reg_write_w = 1; hif.rd_m = 9;
        @(negedge clk); chk("fwd_b_w", hif.forward_b_e, 1);

        cyc(); clr(); hif.res_src_e = 1; hif.rd_e = 7; hif.rs2_d = 7;
        @(negedge clk);
        chk("lw_stall_f", hif.stall_f, 1); chk("lw_stall_d", hif.stall_d, 1);
        chk("lw_flush_e", hif.flush_e, 1); chk("lw_flush_d", hif.flush_d, 0);
        cyc(); hif.rd_e = 0;
        @(negedge clk); chk("lw_x0_stall", hif.stall_f, 0); chk("lw_x0_flush", hif.flush_e, 0);
        cyc(); hif.rd_e = 7; hif.pc_src_e = 1;
        @(negedge clk);
        chk("lwpc_stall_f", hif.stall_f, 1); chk("lwpc_flush_d", hif.flush_d, 1);
        chk("lwpc_flush_e", hif.flush_e, 1);
        cyc(); clr(); hif.pc_src_e = 1;
        @(negedge clk);
        chk("br_flush_d", hif.flush_d, 1); chk("br_flush_e", hif.flush_e, 1);
        chk("br_stall_f", hif.stall_f, 0);

        cyc(); clr(); rst = 1'b1;
        cyc(); rst = 1'b0; hif.mdu_req_e = 1;
        @(negedge clk);
        chk("mdu_start", hif.mdu_start, 1); chk("mdu_start_stall_e", hif.stall_e, 1);
        chk("mdu_start_flush_m", hif.flush_m, 1); chk("mdu_start_busy", hif.mdu_busy, 0);
        cyc(); hif.pc_src_e = 1; hif.res_src_e = 1; hif.rd_e = 3; hif.rs1_d = 3;
        @(negedge clk);
        chk("mdu_b1_busy", hif.mdu_busy, 1); chk("mdu_b1_start", hif.mdu_start, 0);
        chk("mdu_b1_flush_d", hif.flush_d, 0); chk("mdu_b1_flush_e", hif.flush_e, 0);
        cyc(); clr(); hif.mdu_req_e = 1;
        @(negedge clk); chk("mdu_b2_busy", hif.mdu_busy, 1);
        cyc(); hif.mdu_done = 1;
        @(negedge clk); chk("mdu_b3_busy", hif.mdu_busy, 1); chk("mdu_b3_stall", hif.stall_f, 1);
        cyc(); clr();
        @(negedge clk);
        chk("mdu_done_busy", hif.mdu_busy, 0); chk("mdu_done_stall", hif.stall_f, 0);
        chk("mdu_done_count", hif.stall_count, 4);
        cyc(); hif.mdu_done = 1;
        @(negedge clk); chk("stray_done_busy", hif.mdu_busy, 0);
        cyc(); clr();
        @(negedge clk); chk("stray_done_idle", hif.mdu_busy, 0);

        cyc(); hif.mdu_req_e = 1;
        @(negedge clk); chk("to_start", hif.mdu_start, 1);
        for (int i = 0; i < T; i++) begin
            cyc(); clr();
            @(negedge clk); chk("to_busy", hif.mdu_busy, 1); chk("to_flag_early", hif.mdu_timeout, 0);
        end
        cyc();
        @(negedge clk);
        chk("to_idle", hif.mdu_busy, 0); chk("to_flag", hif.mdu_timeout, 1);
        chk("to_count", hif.stall_count, 13);

        cyc(); hif.mdu_req_e = 1;
        @(negedge clk); chk("abort_start", hif.mdu_start, 1);
        cyc();
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_busy", hif.mdu_busy, 0); chk("abort_rst_stall", hif.stall_f, 0);
        chk("abort_rst_start", hif.mdu_start, 0); chk("abort_rst_flush_m", hif.flush_m, 0);
        cyc(); rst = 1'b0; clr();
        @(negedge clk);
        chk("abort_idle", hif.mdu_busy, 0); chk("abort_count", hif.stall_count, 0);
        chk("abort_timeout", hif.mdu_timeout, 0);

        cyc(); hif.res_src_e = 1; hif.rd_e = 4; hif.rs1_d = 4;
        repeat (20) cyc();
        clr();
        @(negedge clk);
        chk("sat_count", hif.stall_count, 15); chk("sat_stall", hif.stall_f, 0);
        cyc();
        @(negedge clk); chk("sat_hold", hif.stall_count, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
